// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e  : controller states
//   F3_*         : RV32I load/store funct3 encodings
//   be_for()     : byte enables for an access size and byte offset
//   st_lanes()   : store data replicated across the byte lanes
//   misaligned() : access error check (alignment, illegal funct3, unsigned store)
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Only funct3[1:0] selects the size; the unsigned bit does not change lanes.
    function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] st_lanes(input logic [2:0] funct3, input logic [31:0] st);
        logic [31:0] lanes;
        lanes = st;
        case (funct3[1:0])
            2'b00:   lanes = {4{st[7:0]}};
            2'b01:   lanes = {2{st[15:0]}};
            default: lanes = st;
        endcase
        return lanes;
    endfunction

    function automatic logic misaligned(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B, F3_BU: err = 1'b0;
            F3_H, F3_HU: err = off[0];
            F3_W:        err = (off != 2'b00);
            default:     err = 1'b1;
        endcase
        // There are no unsigned store variants.
        if (we && funct3[2]) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load data aligner (combinational).
//   rdata  in  32  raw memory word
//   off    in  2   byte offset of the access within the word
//   funct3 in  3   load type (B/H/W/BU/HU)
//   ld_val out 32  selected byte/half/word, sign- or zero-extended
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ld_val = 32'd0;
        case (funct3)
            F3_B:    ld_val = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_val = {24'd0, byte_sel};
            F3_H:    ld_val = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_val = {16'd0, half_sel};
            F3_W:    ld_val = rdata;
            default: ld_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: takes the ALU effective address, runs a
// req/gnt/rvalid handshake with data memory, one operation outstanding.
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_req_valid / o_req_ready      op handshake from the core
//   i_lsu_we, i_lsu_funct3         store flag and RV32I size/sign encoding
//   i_lsu_addr, i_st_data          effective address, rs2 store data
//   o_resp_valid                   one-cycle completion pulse
//   o_ld_data, o_misaligned        load result / access error, valid with resp
//   o_mem_req/we/addr/be/wdata     memory request side (word address)
//   i_mem_gnt                      memory accepted the request
//   i_mem_rvalid, i_mem_rdata      read data return
//
// state | meaning
// IDLE  | ready for a new op
// REQ   | memory request asserted, held until gnt
// WAIT  | load granted, waiting for rvalid
// RESP  | one-cycle response to the core
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_lsu_we,
    input  logic [2:0]        i_lsu_funct3,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [DATA_W-1:0] i_st_data,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_ld_data,
    output logic              o_misaligned,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] ld_q;
    logic [31:0]       ld_val;
    logic              accept;
    logic              acc_err;

    assign accept  = i_req_valid && (state_q == IDLE);
    assign acc_err = misaligned(i_lsu_we, i_lsu_funct3, i_lsu_addr[1:0]);

    lsu_ld_align u_ld_align (
        .rdata  (i_mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .ld_val (ld_val)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= i_lsu_we;
                f3_q    <= i_lsu_funct3;
                off_q   <= i_lsu_addr[1:0];
                addr_q  <= {i_lsu_addr[ADDR_W-1:2], 2'b00};
                be_q    <= be_for(i_lsu_funct3, i_lsu_addr[1:0]);
                wdata_q <= st_lanes(i_lsu_funct3, i_st_data);
                err_q   <= acc_err;
                // Stores and errors report zero load data.
                ld_q    <= '0;
            end else if ((state_q == WAIT) && i_mem_rvalid) begin
                ld_q    <= ld_val;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    state_d = acc_err ? RESP : REQ;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    state_d = we_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_req_ready  = (state_q == IDLE);
    assign o_resp_valid = (state_q == RESP);
    assign o_misaligned = (state_q == RESP) && err_q;
    assign o_ld_data    = ld_q;
    assign o_mem_req    = (state_q == REQ);
    assign o_mem_we     = (state_q == REQ) && we_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_be     = be_q;
    assign o_mem_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] st_data;
    logic        resp_valid;
    logic [31:0] ld_data;
    logic        mis;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_lsu_we     (lsu_we),
        .i_lsu_funct3 (lsu_funct3),
        .i_lsu_addr   (lsu_addr),
        .i_st_data    (st_data),
        .o_resp_valid (resp_valid),
        .o_ld_data    (ld_data),
        .o_misaligned (mis),
        .o_mem_req    (mem_req),
        .i_mem_gnt    (mem_gnt),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_be     (mem_be),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: present op for one cycle (cycle 0).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] st, input string tag);
        req_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = a;
        st_data    = st;
        chk({tag, " ready@0"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                           input logic [3:0] exp_be, input logic [31:0] exp_ld,
                           input string tag);
        issue(1'b0, f3, a, 32'h0, tag);
        chk({tag, " req@1"},  {31'd0, mem_req}, 32'd1);
        chk({tag, " we@1"},   {31'd0, mem_we},  32'd0);
        chk({tag, " addr@1"}, mem_addr, a & 32'hFFFF_FFFC);
        chk({tag, " be@1"},   {28'd0, mem_be}, {28'd0, exp_be});
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk({tag, " req@2"},  {31'd0, mem_req},    32'd0);
        chk({tag, " resp@2"}, {31'd0, resp_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk({tag, " resp@3"},  {31'd0, resp_valid}, 32'd1);
        chk({tag, " ld@3"},    ld_data, exp_ld);
        chk({tag, " mis@3"},   {31'd0, mis}, 32'd0);
        chk({tag, " ready@3"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, " resp@4"},  {31'd0, resp_valid}, 32'd0);
        chk({tag, " ready@4"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_err(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input string tag);
        issue(we, f3, a, 32'h1234_5678, tag);
        chk({tag, " resp@1"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, " mis@1"},  {31'd0, mis}, 32'd1);
        chk({tag, " req@1"},  {31'd0, mem_req}, 32'd0);
        chk({tag, " ld@1"},   ld_data, 32'd0);
        @(negedge clk);
        chk({tag, " req@2"},   {31'd0, mem_req}, 32'd0);
        chk({tag, " resp@2"},  {31'd0, resp_valid}, 32'd0);
        chk({tag, " ready@2"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        lsu_we     = 1'b0;
        lsu_funct3 = 3'd0;
        lsu_addr   = 32'd0;
        st_data    = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        repeat (2) @(negedge clk);

        chk("rst ready", {31'd0, req_ready},  32'd1);
        chk("rst resp",  {31'd0, resp_valid}, 32'd0);
        chk("rst mis",   {31'd0, mis},        32'd0);
        chk("rst req",   {31'd0, mem_req},    32'd0);
        chk("rst we",    {31'd0, mem_we},     32'd0);
        chk("rst ld",    ld_data,   32'd0);
        chk("rst addr",  mem_addr,  32'd0);
        chk("rst be",    {28'd0, mem_be}, 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_load(3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "lw");
        do_load(3'b000, 32'h103, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80, "lb");
        do_load(3'b100, 32'h103, 32'h80FF_0000, 4'b1000, 32'h0000_0080, "lbu");
        do_load(3'b101, 32'h102, 32'h80FF_0000, 4'b1100, 32'h0000_80FF, "lhu");
        do_load(3'b001, 32'h102, 32'h80FF_0000, 4'b1100, 32'hFFFF_80FF, "lh");
        do_load(3'b000, 32'h101, 32'h0000_7F00, 4'b0010, 32'h0000_007F, "lb pos");

        // SB with grant stalled for three cycles.
        issue(1'b1, 3'b000, 32'h201, 32'h0000_00AB, "sb");
        for (int i = 0; i < 3; i++) begin
            chk("sb stall req",   {31'd0, mem_req}, 32'd1);
            chk("sb stall we",    {31'd0, mem_we},  32'd1);
            chk("sb stall addr",  mem_addr, 32'h200);
            chk("sb stall be",    {28'd0, mem_be}, 32'b0010);
            chk("sb stall wdata", mem_wdata, 32'hABAB_ABAB);
            chk("sb stall resp",  {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("sb req@gnt", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("sb resp", {31'd0, resp_valid}, 32'd1);
        chk("sb mis",  {31'd0, mis}, 32'd0);
        chk("sb ld",   ld_data, 32'd0);
        chk("sb req after gnt", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("sb ready", {31'd0, req_ready}, 32'd1);

        // SH lanes on the upper half.
        issue(1'b1, 3'b001, 32'h302, 32'hFFFF_1234, "sh");
        chk("sh be",    {28'd0, mem_be}, 32'b1100);
        chk("sh wdata", mem_wdata, 32'h1234_1234);
        chk("sh addr",  mem_addr, 32'h300);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("sh resp", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);

        do_err(1'b0, 3'b010, 32'h102, "lw mis");
        do_err(1'b1, 3'b001, 32'h301, "sh mis");
        do_err(1'b0, 3'b011, 32'h100, "f3 011");
        do_err(1'b1, 3'b100, 32'h100, "sbu");

        // Reset while waiting for read data; late rvalid must be dropped.
        issue(1'b0, 3'b010, 32'h500, 32'h0, "rst wait");
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rstw in wait", {31'd0, mem_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        chk("rstw ready", {31'd0, req_ready},  32'd1);
        chk("rstw resp",  {31'd0, resp_valid}, 32'd0);
        chk("rstw req",   {31'd0, mem_req},    32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk("rstw late resp",  {31'd0, resp_valid}, 32'd0);
        chk("rstw late ready", {31'd0, req_ready},  32'd1);
        chk("rstw late ld",    ld_data, 32'd0);
        @(negedge clk);
        chk("rstw after resp", {31'd0, resp_valid}, 32'd0);

        // Back-to-back SW then LW with valid held high and grant always on.
        mem_gnt    = 1'b1;
        req_valid  = 1'b1;
        lsu_we     = 1'b1;
        lsu_funct3 = 3'b010;
        lsu_addr   = 32'h400;
        st_data    = 32'h1234_5678;
        chk("b2b ready@0", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        lsu_we     = 1'b0;
        lsu_addr   = 32'h404;
        st_data    = 32'h0;
        chk("b2b sw ready@1", {31'd0, req_ready}, 32'd0);
        chk("b2b sw req",     {31'd0, mem_req},   32'd1);
        chk("b2b sw we",      {31'd0, mem_we},    32'd1);
        chk("b2b sw wdata",   mem_wdata, 32'h1234_5678);
        chk("b2b sw addr",    mem_addr,  32'h400);
        @(negedge clk);
        chk("b2b sw resp",     {31'd0, resp_valid}, 32'd1);
        chk("b2b sw ready@2",  {31'd0, req_ready},  32'd0);
        @(negedge clk);
        chk("b2b lw ready@3",  {31'd0, req_ready},  32'd1);
        chk("b2b lw resp@3",   {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b lw req",  {31'd0, mem_req}, 32'd1);
        chk("b2b lw we",   {31'd0, mem_we},  32'd0);
        chk("b2b lw addr", mem_addr, 32'h404);
        chk("b2b lw ready@4", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("b2b lw resp", {31'd0, resp_valid}, 32'd1);
        chk("b2b lw ld",   ld_data, 32'hCAFE_F00D);
        @(negedge clk);
        chk("b2b idle ready", {31'd0, req_ready}, 32'd1);
        chk("b2b idle req",   {31'd0, mem_req},   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
